// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the single-port RAM controller and its storage array.
package sp_ram_pkg;

    typedef enum logic [1:0] {
        WRITE_FIRST,
        READ_FIRST,
        NO_CHANGE
    } read_mode_t;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Single-port synchronous storage with per-byte write enables and a registered read port.
// Kept to one address/we/be/wdata port so it maps onto vendor block RAM.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         BYTE_WIDTH = 8,
    parameter int         ADDR_WIDTH = 8,
    parameter read_mode_t READ_MODE  = WRITE_FIRST
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           ce,
    input  logic                                           we,
    input  logic                                           oe,
    input  logic [ADDR_WIDTH-1:0]                          addr,
    input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0]   be,
    input  logic [DATA_WIDTH-1:0]                          wdata,
    output logic [DATA_WIDTH-1:0]                          rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < num_bytes(DATA_WIDTH, BYTE_WIDTH); i++) begin
            if (be[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (ce && we) begin
            for (int i = 0; i < num_bytes(DATA_WIDTH, BYTE_WIDTH); i++) begin
                if (be[i]) mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // oe separates request accesses from clear-engine writes, which must not disturb rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (ce && oe) begin
            if (!we) begin
                rdata <= mem[addr];
            end else begin
                case (READ_MODE)
                    WRITE_FIRST: rdata <= merged;
                    READ_FIRST:  rdata <= mem[addr];
                    default:     rdata <= rdata;
                endcase
            end
        end
    end

endmodule

// File: rtl/sp_ram_ctl.sv
// Parametrised single-port RAM controller: valid/ready request port, response strobe,
// optional output register and a sequential clear engine.
module sp_ram_ctl
    import sp_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 8,
    parameter read_mode_t            READ_MODE      = WRITE_FIRST,
    parameter bit                    OUT_REG        = 1'b0,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           clr,
    output logic                                           busy,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_write,
    input  logic [ADDR_WIDTH-1:0]                          req_addr,
    input  logic [DATA_WIDTH-1:0]                          req_wdata,
    input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0]   req_be,
    output logic                                           rsp_valid,
    output logic [DATA_WIDTH-1:0]                          rsp_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("sp_ram_ctl: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_nxt;
    logic                  accept;
    logic                  mem_ce, mem_we, mem_oe;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0] mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
    logic                  vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        req_ready   = (state == IDLE) && !clr;
        accept      = req_valid && req_ready;
        mem_ce      = accept;
        mem_we      = req_write;
        mem_oe      = accept;
        mem_addr    = req_addr;
        mem_be      = req_be;
        mem_wdata   = req_wdata;
        case (state)
            CLEAR: begin
                mem_ce    = 1'b1;
                mem_we    = 1'b1;
                mem_oe    = 1'b0;
                mem_addr  = clr_ptr;
                mem_be    = '1;
                mem_wdata = CLEAR_VALUE;
                if (clr_ptr == LAST_ADDR) begin
                    state_nxt   = IDLE;
                    clr_ptr_nxt = '0;
                end else begin
                    clr_ptr_nxt = clr_ptr + ADDR_WIDTH'(1);
                end
            end
            IDLE: begin
                if (clr) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing touches the array while reset is held.
        if (rst) mem_ce = 1'b0;
    end

    assign busy = (state == CLEAR);

    sp_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .READ_MODE  (READ_MODE)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .ce    (mem_ce),
        .we    (mem_we),
        .oe    (mem_oe),
        .addr  (mem_addr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= accept;
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic                  vld_q2;
            logic [DATA_WIDTH-1:0] data_q2;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q2  <= 1'b0;
                    data_q2 <= '0;
                end else begin
                    vld_q2 <= vld_q;
                    if (vld_q) data_q2 <= mem_rdata;
                end
            end
            assign rsp_valid = vld_q2;
            assign rsp_data  = data_q2;
        end else begin : g_no_out_reg
            assign rsp_valid = vld_q;
            assign rsp_data  = mem_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_ctl.sv
// Directed bench for sp_ram_ctl: lockstep 8-bit instances in each read mode / OUT_REG, plus a 32-bit byte-lane instance.
module tb_sp_ram_ctl;
    import sp_ram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       clr = 1'b0, v = 1'b0, w = 1'b0;
    logic [3:0] a = '0;
    logic [7:0] wd = '0;
    logic [0:0] be = '0;

    logic       busy_wf, rdy_wf, rv_wf, busy_rf, rdy_rf, rv_rf;
    logic       busy_nc, rdy_nc, rv_nc, busy_or, rdy_or, rv_or;
    logic [7:0] rd_wf, rd_rf, rd_nc, rd_or;

    logic        clr32 = 1'b0, v32 = 1'b0, w32 = 1'b0;
    logic [3:0]  a32 = '0, be32 = '0;
    logic [31:0] wd32 = '0;
    logic        busy32, rdy32, rv32;
    logic [31:0] rd32;

    sp_ram_ctl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(WRITE_FIRST), .OUT_REG(1'b0),
                 .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)) d_wf (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_wf), .req_valid(v), .req_ready(rdy_wf),
        .req_write(w), .req_addr(a), .req_wdata(wd), .req_be(be), .rsp_valid(rv_wf), .rsp_data(rd_wf));

    sp_ram_ctl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(READ_FIRST), .OUT_REG(1'b0),
                 .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)) d_rf (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_rf), .req_valid(v), .req_ready(rdy_rf),
        .req_write(w), .req_addr(a), .req_wdata(wd), .req_be(be), .rsp_valid(rv_rf), .rsp_data(rd_rf));

    sp_ram_ctl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(NO_CHANGE), .OUT_REG(1'b0),
                 .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)) d_nc (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_nc), .req_valid(v), .req_ready(rdy_nc),
        .req_write(w), .req_addr(a), .req_wdata(wd), .req_be(be), .rsp_valid(rv_nc), .rsp_data(rd_nc));

    sp_ram_ctl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(WRITE_FIRST), .OUT_REG(1'b1),
                 .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)) d_or (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_or), .req_valid(v), .req_ready(rdy_or),
        .req_write(w), .req_addr(a), .req_wdata(wd), .req_be(be), .rsp_valid(rv_or), .rsp_data(rd_or));

    sp_ram_ctl #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(WRITE_FIRST),
                 .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(32'h0)) d_32 (
        .clk(clk), .rst(rst), .clr(clr32), .busy(busy32), .req_valid(v32), .req_ready(rdy32),
        .req_write(w32), .req_addr(a32), .req_wdata(wd32), .req_be(be32), .rsp_valid(rv32), .rsp_data(rd32));

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       be;
        logic [7:0] e_wf;
        logic [7:0] e_rf;
        logic [7:0] e_nc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void add(input logic wr, input logic [3:0] ad, input logic [7:0] d,
                                input logic b, input logic [7:0] ewf, input logic [7:0] erf,
                                input logic [7:0] enc);
        vec_t t;
        t.wr = wr; t.addr = ad; t.wdata = d; t.be = b;
        t.e_wf = ewf; t.e_rf = erf; t.e_nc = enc;
        vecs.push_back(t);
    endfunction

    // Counts samples with busy high, starting from the current one; bounded.
    task automatic count_busy(input string name);
        int n = 0;
        while (busy_wf && n < 40) begin
            n++;
            tick();
        end
        chk(name, n, 16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Vector table: lockstep across the 8-bit instances, req_valid held high throughout.
        for (int i = 0; i < 16; i++) add(1'b0, 4'(i), 8'h00, 1'b1, 8'hA5, 8'hA5, 8'hA5);
        add(1'b1, 4'd3, 8'h10, 1'b1, 8'h10, 8'hA5, 8'hA5);
        add(1'b1, 4'd3, 8'h20, 1'b1, 8'h20, 8'h10, 8'hA5);
        add(1'b0, 4'd3, 8'h00, 1'b1, 8'h20, 8'h20, 8'h20);
        for (int i = 0; i < 8; i++)
            add(1'b1, 4'(i), 8'h30 + 8'(i), 1'b1, 8'h30 + 8'(i), (i == 3) ? 8'h20 : 8'hA5, 8'h20);
        for (int i = 0; i < 8; i++)
            add(1'b0, 4'(i), 8'h00, 1'b1, 8'h30 + 8'(i), 8'h30 + 8'(i), 8'h30 + 8'(i));
        add(1'b1, 4'd9, 8'h5A, 1'b1, 8'h5A, 8'hA5, 8'h37);
        add(1'b0, 4'd9, 8'h00, 1'b1, 8'h5A, 8'h5A, 8'h5A);
        add(1'b1, 4'd0, 8'hFF, 1'b0, 8'h30, 8'h30, 8'h5A);
        add(1'b0, 4'd0, 8'h00, 1'b1, 8'h30, 8'h30, 8'h30);

        // Reset state
        repeat (3) tick();
        chk("reset busy_wf", busy_wf, 1);
        chk("reset rv_wf", rv_wf, 0);
        chk("reset rd_wf", rd_wf, 0);
        chk("reset rv_or", rv_or, 0);
        chk("reset rd_or", rd_or, 0);
        chk("reset busy32", busy32, 0);
        chk("reset rv32", rv32, 0);

        // Release reset; the 32-bit instance (no clear) accepts at the first edge
        rst = 1'b0;
        #1;
        chk("no-clear rdy32", rdy32, 1);
        v32 = 1'b1; w32 = 1'b1; a32 = 4'd2; wd32 = 32'h11223344; be32 = 4'hF;
        tick();
        v32 = 1'b0;
        chk("first write rv32", rv32, 1);
        chk("first write rd32", rd32, 32'h11223344);
        // busy was high at the pre-edge sample too; count_busy starts from this one
        begin
            int n = 1;
            while (busy_wf && n < 40) begin
                n++;
                tick();
            end
            chk("reset clear busy cycles", n, 16);
        end
        chk("ready after clear", rdy_wf, 1);
        chk("ready after clear or", rdy_or, 1);
        chk("busy_rf after clear", busy_rf, 0);

        // Byte-enable merge on the 32-bit instance
        v32 = 1'b1; w32 = 1'b1; a32 = 4'd2; wd32 = 32'hAABBCCDD; be32 = 4'b0101;
        tick();
        chk("be merge write rsp", rd32, 32'h11BB33DD);
        chk("be merge write rv", rv32, 1);
        w32 = 1'b0;
        tick();
        v32 = 1'b0;
        chk("be merge read rsp", rd32, 32'h11BB33DD);
        tick();
        chk("rv32 idle", rv32, 0);

        // Table-driven back-to-back traffic
        for (int i = 0; i < vecs.size(); i++) begin
            v = 1'b1; w = vecs[i].wr; a = vecs[i].addr; wd = vecs[i].wdata; be = vecs[i].be;
            tick();
            chk($sformatf("vec%0d rv_wf", i), rv_wf, 1);
            chk($sformatf("vec%0d rd_wf", i), rd_wf, vecs[i].e_wf);
            chk($sformatf("vec%0d rd_rf", i), rd_rf, vecs[i].e_rf);
            chk($sformatf("vec%0d rv_nc", i), rv_nc, 1);
            chk($sformatf("vec%0d rd_nc", i), rd_nc, vecs[i].e_nc);
            chk($sformatf("vec%0d rv_or", i), rv_or, (i > 0) ? 1 : 0);
            if (i > 0) chk($sformatf("vec%0d rd_or", i), rd_or, vecs[i-1].e_wf);
        end
        v = 1'b0; w = 1'b0; be = 1'b1;
        tick();
        chk("table tail rv_or", rv_or, 1);
        chk("table tail rd_or", rd_or, vecs[vecs.size()-1].e_wf);
        chk("table tail rv_wf", rv_wf, 0);
        tick();
        chk("table idle rv_or", rv_or, 0);

        // clr / request collision with a read already in flight
        v = 1'b1; w = 1'b0; a = 4'd5;
        tick();
        clr = 1'b1; w = 1'b1; a = 4'd6; wd = 8'h77;
        #1;
        chk("collision rdy_wf", rdy_wf, 0);
        chk("collision rdy_or", rdy_or, 0);
        chk("inflight rv_wf", rv_wf, 1);
        chk("inflight rd_wf", rd_wf, 8'h35);
        tick();
        clr = 1'b0; v = 1'b0; w = 1'b0;
        chk("collision busy", busy_wf, 1);
        chk("collision no rsp", rv_wf, 0);
        chk("inflight rv_or", rv_or, 1);
        chk("inflight rd_or", rd_or, 8'h35);
        count_busy("clr sweep busy cycles");
        v = 1'b1; a = 4'd6;
        tick();
        chk("dropped write addr6", rd_wf, 8'hA5);
        a = 4'd5;
        tick();
        chk("cleared addr5", rd_wf, 8'hA5);
        w = 1'b1; a = 4'd12; wd = 8'h66;
        tick();
        v = 1'b0; w = 1'b0;
        chk("write addr12", rd_wf, 8'h66);

        // Reset mid-clear at clr_ptr == 7
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        chk("mid-clear busy", busy_wf, 1);
        rst = 1'b1;
        v32 = 1'b1; w32 = 1'b0; a32 = 4'd2;
        tick();
        v32 = 1'b0;
        rst = 1'b0;
        chk("mid-clear rst rv_wf", rv_wf, 0);
        chk("mid-clear rst rd_wf", rd_wf, 0);
        chk("mid-clear rst rv32", rv32, 0);
        chk("mid-clear rst busy", busy_wf, 1);
        count_busy("restart sweep busy cycles");
        for (int i = 0; i < 16; i++) begin
            v = 1'b1; a = 4'(i);
            tick();
            chk($sformatf("post-restart rv addr%0d", i), rv_wf, 1);
            chk($sformatf("post-restart rd addr%0d", i), rd_wf, 8'hA5);
        end
        v = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
